// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   - FSM state encodings and the enumerated state type
//   - parity mode constants (none / even / odd)
//   - clock and baud constants (30 MHz system clock, /3125 for 9600 baud)
//   - parity_bit(): parity helper for frames of up to 8 data bits
// -----------------------------------------------------------------------------
package uart_pkg;

  // State encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SYNC   = ST_SYNC,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_e;

  // Parity modes
  localparam int unsigned PARITY_NONE = 32'd0;
  localparam int unsigned PARITY_EVEN = 32'd1;
  localparam int unsigned PARITY_ODD  = 32'd2;

  // Clocking: 30_000_000 / 3125 = 9600 baud
  localparam int unsigned CLK_HZ        = 32'd30_000_000;
  localparam int unsigned BAUD_DIV_9600 = 32'd3125;

  // Parity bit for a data word zero-extended to 8 bits. Zero padding does not
  // change the XOR reduction, so narrower frames can share this helper.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    logic red;
    red = ^data;
    case (mode)
      PARITY_EVEN: return red;
      PARITY_ODD:  return ~red;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmit serializer driven by an external one-cycle baud pulse.
// Accepts a word over valid/ready and shifts it out as
//   start(0), data LSB first, optional parity, STOP_BITS stop(1).
// The baud divider lives outside this block; only its tick is consumed here.
//
// Parameters
//   DATA_BITS  data bits per frame (5..8)
//   PARITY     PARITY_NONE / PARITY_EVEN / PARITY_ODD
//   STOP_BITS  stop bits per frame (1..2)
// Ports
//   clk30M     in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   baud_tick  in   one-cycle pulse per bit period
//   tx_data    in   word to send, sampled on handshake only
//   tx_valid   in   tx_data is valid
//   tx_ready   out  high only while idle; transfer on tx_valid && tx_ready
//   tx         out  registered serial line, idle high
//   tx_busy    out  high from the cycle after acceptance until back to idle
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PARITY_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk30M,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned      CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q;
  logic                 tx_busy_q;

  // Next-state, datapath and next tx value. tx_d is the line level for the
  // state being entered, so the registered tx follows each tick by one cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = 1'b1;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // baud_tick is deliberately ignored here: a tick in the acceptance
        // cycle must not start the frame early.
        if (tx_valid && tx_ready_q) begin
          state_d    = S_SYNC;
          shift_d    = tx_data;
          parity_d   = parity_bit(8'(tx_data), PARITY);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SYNC: begin
        // Align the start bit to the baud grid.
        if (baud_tick) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end

      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = S_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          tx_d = shift_q[0];
        end
      end

      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end else begin
          tx_d = parity_q;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk30M) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      // Ready/busy are registered from the next state so they track the
      // state register exactly and stay complementary.
      tx_ready_q <= (state_d == S_IDLE);
      tx_busy_q  <= (state_d != S_IDLE);
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
// Three instances (8N1, 8E1, 8O2) share clock, reset, tick and data. The bench
// owns the tick schedule: a tick occurs at edge e when e % period == phase.
// Expected waveforms come from a frame-level model: bit list from the byte,
// start of frame = first tick edge strictly after acceptance, each bit lasts
// one period, ready returns on the edge of the final stop tick.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] valid_v = 3'b000;
  logic [2:0] tx_v, rdy_v, busy_v;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint period = 16;
  longint phase = 0;
  bit     tick_en = 1'b0;

  int par_cfg  [3] = '{0, 1, 2};
  int stop_cfg [3] = '{1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk30M(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(valid_v[0]), .tx_ready(rdy_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk30M(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(valid_v[1]), .tx_ready(rdy_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8o2 (
    .clk30M(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(valid_v[2]), .tx_ready(rdy_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]));

  // Advance one clock: set tick for the coming edge at negedge, sample #1 after.
  task automatic clk_step();
    @(negedge clk);
    baud_tick = tick_en && (((cyc + 1) % period) == phase);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Send one frame on instance inst and compare tx/ready/busy every cycle
  // from acceptance through the first idle cycle. With rst_bit >= 0, reset is
  // pulsed in the middle of that frame bit and the post-reset state checked.
  task automatic run_frame(input int inst, input logic [7:0] data,
                           input logic [7:0] next_data, input bit hold,
                           input int rst_bit, input string tname);
    int     bits[$];
    int     ones;
    int     nbits;
    int     k;
    longint a, s, e, rst_at;
    logic   etx, erdy, ebusy;
    bit     bad;

    bits = {};
    ones = 0;
    bits.push_back(0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(int'(data[i]));
      ones += int'(data[i]);
    end
    if (par_cfg[inst] == 1) bits.push_back(ones % 2);
    if (par_cfg[inst] == 2) bits.push_back(1 - (ones % 2));
    for (int i = 0; i < stop_cfg[inst]; i++) bits.push_back(1);
    nbits = bits.size();

    tx_data = data;
    valid_v[inst] = 1'b1;
    a = cyc + 1;
    s = a + 1;
    while ((s % period) != phase) s++;
    e = s + longint'(nbits) * period;
    rst_at = (rst_bit >= 0) ? (s + longint'(rst_bit) * period + period / 2) : -1;

    clk_step();
    if (!hold) valid_v[inst] = 1'b0;
    tx_data = next_data;
    bad = 1'b0;

    while (1) begin
      if (cyc < s) begin
        etx = 1'b1;
      end else begin
        k = int'((cyc - s) / period);
        etx = (k < nbits) ? (bits[k] != 0) : 1'b1;
      end
      erdy  = (cyc >= e);
      ebusy = !erdy;
      if (!bad) begin
        checks++;
        if (tx_v[inst] !== etx) begin
          errors++; bad = 1'b1;
          $display("FAIL %s tx inst%0d cycle %0d: got %b expected %b", tname, inst, cyc - a, tx_v[inst], etx);
        end
        checks++;
        if (rdy_v[inst] !== erdy) begin
          errors++; bad = 1'b1;
          $display("FAIL %s tx_ready inst%0d cycle %0d: got %b expected %b", tname, inst, cyc - a, rdy_v[inst], erdy);
        end
        checks++;
        if (busy_v[inst] !== ebusy) begin
          errors++; bad = 1'b1;
          $display("FAIL %s tx_busy inst%0d cycle %0d: got %b expected %b", tname, inst, cyc - a, busy_v[inst], ebusy);
        end
      end
      if (cyc >= e) break;
      if (cyc + 1 == rst_at) begin
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        checks++;
        if (tx_v[inst] !== 1'b1) begin
          errors++;
          $display("FAIL %s tx after reset: got %b expected 1", tname, tx_v[inst]);
        end
        checks++;
        if (rdy_v[inst] !== 1'b1) begin
          errors++;
          $display("FAIL %s tx_ready after reset: got %b expected 1", tname, rdy_v[inst]);
        end
        checks++;
        if (busy_v[inst] !== 1'b0) begin
          errors++;
          $display("FAIL %s tx_busy after reset: got %b expected 0", tname, busy_v[inst]);
        end
        return;
      end
      clk_step();
    end
  endtask

  task automatic test_reset();
    tick_en = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rst = 1'b0;
      clk_step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tx_v[i] !== 1'b1) begin
          errors++;
          $display("FAIL reset tx inst%0d cycle %0d: got %b expected 1", i, c, tx_v[i]);
        end
        checks++;
        if (rdy_v[i] !== 1'b1) begin
          errors++;
          $display("FAIL reset tx_ready inst%0d cycle %0d: got %b expected 1", i, c, rdy_v[i]);
        end
        checks++;
        if (busy_v[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset tx_busy inst%0d cycle %0d: got %b expected 0", i, c, busy_v[i]);
        end
      end
    end
    tick_en = 1'b1;
  endtask

  task automatic test_8n1_real_baud();
    period = 3125;
    phase  = longint'($urandom_range(0, 3124));
    run_frame(0, 8'h55, 8'($urandom), 1'b0, -1, "8n1_0x55");
  endtask

  task automatic test_parity();
    period = 16;
    phase  = longint'($urandom_range(0, 15));
    run_frame(1, 8'h07, 8'($urandom), 1'b0, -1, "even_0x07");
    run_frame(2, 8'h07, 8'($urandom), 1'b0, -1, "odd_0x07");
  endtask

  task automatic test_accept_on_tick();
    period = 20;
    phase  = (cyc + 1) % period;
    run_frame(0, 8'($urandom), 8'($urandom), 1'b0, -1, "accept_on_tick");
    period = 9;
    phase  = (cyc + 1) % period;
    run_frame(1, 8'($urandom), 8'($urandom), 1'b0, -1, "accept_on_tick_e");
  endtask

  task automatic test_reset_mid_frame();
    period = 16;
    phase  = longint'($urandom_range(0, 15));
    run_frame(0, 8'hA3, 8'($urandom), 1'b0, 4, "reset_mid_0xA3");
    run_frame(0, 8'h3C, 8'($urandom), 1'b0, -1, "after_reset_0x3C");
  endtask

  task automatic test_back_to_back();
    period = 12;
    phase  = longint'($urandom_range(0, 11));
    run_frame(2, 8'h11, 8'h22, 1'b1, -1, "hold_valid_0x11");
    run_frame(2, 8'h22, 8'h5A, 1'b1, -1, "hold_valid_0x22");
    valid_v = 3'b000;
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      period = longint'($urandom_range(6, 40));
      phase  = longint'($urandom_range(0, 32'(period - 1)));
      run_frame(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'b0, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_8n1_real_baud();
    test_parity();
    test_accept_on_tick();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net in case the run stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
